// File: rtl/code_accum_pkg.sv
// Shared constants, types and helpers for the code_accum channel correlator.
// Optional build macro: CODE_ACCUM_SAT_EN (saturating accumulation).
package code_accum_pkg;

  parameter int unsigned ACC_W = 16;

  localparam int unsigned EPOCH_MAX = 19;
  localparam int unsigned EPOCH_W   = 5;

  typedef logic signed [ACC_W-1:0] acc_t;

  // Signed add clamped to the range of a w-bit two's-complement value (w <= 31).
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = 33'(a) + 33'(b);
    hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (w - 1));
    if (sum > hi) begin
      return hi[31:0];
    end else if (sum < lo) begin
      return lo[31:0];
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/code_accum_arm.sv
// One code replica: despreads I and Q against a single code chip and integrates
// them, latching the sums on a dump. Saturates when CODE_ACCUM_SAT_EN is defined.
module code_accum_arm
  import code_accum_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 3,
  parameter int unsigned ACC_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_en,
  input  logic                       i_valid,
  input  logic                       i_dump,
  input  logic                       i_code,
  input  logic signed [SAMPLE_W-1:0] i_i_sample,
  input  logic signed [SAMPLE_W-1:0] i_q_sample,
  output logic signed [ACC_W-1:0]    o_i_lat,
  output logic signed [ACC_W-1:0]    o_q_lat
);

  logic signed [ACC_W-1:0] w_i_ext, w_q_ext;
  logic signed [ACC_W-1:0] w_i_add, w_q_add;
  logic signed [ACC_W-1:0] w_i_sum, w_q_sum;
  logic signed [ACC_W-1:0] r_i_acc, r_q_acc;
  logic signed [ACC_W-1:0] r_i_lat, r_q_lat;

  // Product (sign-extend, negate on chip 0) and the accumulator-plus-product sum.
  // Negating after extension keeps -4 -> +4 exact.
  always_comb begin
    w_i_ext = ACC_W'(i_i_sample);
    w_q_ext = ACC_W'(i_q_sample);
    w_i_add = '0;
    w_q_add = '0;
    if (i_valid) begin
      w_i_add = i_code ? w_i_ext : -w_i_ext;
      w_q_add = i_code ? w_q_ext : -w_q_ext;
    end
`ifdef CODE_ACCUM_SAT_EN
    w_i_sum = ACC_W'(sat_add(32'(r_i_acc), 32'(w_i_add), ACC_W));
    w_q_sum = ACC_W'(sat_add(32'(r_q_acc), 32'(w_q_add), ACC_W));
`else
    w_i_sum = r_i_acc + w_i_add;
    w_q_sum = r_q_acc + w_q_add;
`endif
  end

  // Integrate, or latch-and-restart on a dump; disabled channel holds zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_acc <= '0;
      r_q_acc <= '0;
      r_i_lat <= '0;
      r_q_lat <= '0;
    end else if (!i_en) begin
      r_i_acc <= '0;
      r_q_acc <= '0;
    end else if (i_dump) begin
      r_i_lat <= w_i_sum;
      r_q_lat <= w_q_sum;
      r_i_acc <= '0;
      r_q_acc <= '0;
    end else begin
      r_i_acc <= w_i_sum;
      r_q_acc <= w_q_sum;
    end
  end

  assign o_i_lat = r_i_lat;
  assign o_q_lat = r_q_lat;

endmodule

// File: rtl/code_accum.sv
// Per-channel early/prompt/late correlator with dump latch, read-cleared ready
// and overrun flags, and a 0..19 epoch counter.
// Optional build macro: CODE_ACCUM_SAT_EN (saturating accumulation).
module code_accum
  import code_accum_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 3,
  parameter int unsigned ACC_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ch_enable,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic signed [SAMPLE_W-1:0] q_sample,
  input  logic                       early,
  input  logic                       prompt,
  input  logic                       late,
  input  logic                       dump_enable,
  input  logic                       status_read,
  input  logic                       epoch_load,
  input  logic [EPOCH_W-1:0]         epoch_load_val,
  output logic signed [ACC_W-1:0]    i_early,
  output logic signed [ACC_W-1:0]    q_early,
  output logic signed [ACC_W-1:0]    i_prompt,
  output logic signed [ACC_W-1:0]    q_prompt,
  output logic signed [ACC_W-1:0]    i_late,
  output logic signed [ACC_W-1:0]    q_late,
  output logic                       dump_valid,
  output logic                       accum_ready,
  output logic                       overrun,
  output logic [EPOCH_W-1:0]         epoch
);

  logic               w_dump;
  logic               r_dump_valid;
  logic               r_ready;
  logic               r_overrun;
  logic [EPOCH_W-1:0] r_epoch;

  assign w_dump = ch_enable & dump_enable;

  code_accum_arm #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_arm_early (
    .clk        (clk),
    .rst        (rst),
    .i_en       (ch_enable),
    .i_valid    (sample_valid),
    .i_dump     (dump_enable),
    .i_code     (early),
    .i_i_sample (i_sample),
    .i_q_sample (q_sample),
    .o_i_lat    (i_early),
    .o_q_lat    (q_early)
  );

  code_accum_arm #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_arm_prompt (
    .clk        (clk),
    .rst        (rst),
    .i_en       (ch_enable),
    .i_valid    (sample_valid),
    .i_dump     (dump_enable),
    .i_code     (prompt),
    .i_i_sample (i_sample),
    .i_q_sample (q_sample),
    .o_i_lat    (i_prompt),
    .o_q_lat    (q_prompt)
  );

  code_accum_arm #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_arm_late (
    .clk        (clk),
    .rst        (rst),
    .i_en       (ch_enable),
    .i_valid    (sample_valid),
    .i_dump     (dump_enable),
    .i_code     (late),
    .i_i_sample (i_sample),
    .i_q_sample (q_sample),
    .o_i_lat    (i_late),
    .o_q_lat    (q_late)
  );

  // Status flags: ready set wins over read; a read alongside a dump consumes
  // the old data so it does not count as an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dump_valid <= 1'b0;
      r_ready      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_dump_valid <= w_dump;
      if (w_dump && r_ready && !status_read) begin
        r_overrun <= 1'b1;
      end else if (status_read) begin
        r_overrun <= 1'b0;
      end
      if (w_dump) begin
        r_ready <= 1'b1;
      end else if (status_read) begin
        r_ready <= 1'b0;
      end
    end
  end

  // Epoch counter: load beats increment; out-of-range loads clamp to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_epoch <= '0;
    end else if (epoch_load) begin
      r_epoch <= (epoch_load_val > EPOCH_W'(EPOCH_MAX)) ? '0 : epoch_load_val;
    end else if (w_dump) begin
      r_epoch <= (r_epoch == EPOCH_W'(EPOCH_MAX)) ? '0 : r_epoch + 1'b1;
    end
  end

  assign dump_valid  = r_dump_valid;
  assign accum_ready = r_ready;
  assign overrun     = r_overrun;
  assign epoch       = r_epoch;

endmodule

// File: tb/tb_code_accum.sv
// Self-checking bench for code_accum: directed scenarios plus a randomized run
// compared against an integer-arithmetic reference model.
module tb_code_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, ch_enable, sample_valid, early, prompt, late;
  logic              dump_enable, status_read, epoch_load;
  logic signed [2:0] i_sample, q_sample;
  logic [4:0]        epoch_load_val;

  logic signed [15:0] i_early, q_early, i_prompt, q_prompt, i_late, q_late;
  logic               dump_valid, accum_ready, overrun;
  logic [4:0]         epoch;

  logic signed [7:0] s_i_early, s_q_early, s_i_prompt, s_q_prompt, s_i_late, s_q_late;
  logic              s_dump_valid, s_accum_ready, s_overrun;
  logic [4:0]        s_epoch;

  code_accum #(.SAMPLE_W(3), .ACC_W(16)) u_dut (
    .clk(clk), .rst(rst), .ch_enable(ch_enable), .sample_valid(sample_valid),
    .i_sample(i_sample), .q_sample(q_sample), .early(early), .prompt(prompt), .late(late),
    .dump_enable(dump_enable), .status_read(status_read), .epoch_load(epoch_load),
    .epoch_load_val(epoch_load_val), .i_early(i_early), .q_early(q_early),
    .i_prompt(i_prompt), .q_prompt(q_prompt), .i_late(i_late), .q_late(q_late),
    .dump_valid(dump_valid), .accum_ready(accum_ready), .overrun(overrun), .epoch(epoch)
  );

  code_accum #(.SAMPLE_W(3), .ACC_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .ch_enable(ch_enable), .sample_valid(sample_valid),
    .i_sample(i_sample), .q_sample(q_sample), .early(early), .prompt(prompt), .late(late),
    .dump_enable(dump_enable), .status_read(status_read), .epoch_load(epoch_load),
    .epoch_load_val(epoch_load_val), .i_early(s_i_early), .q_early(s_q_early),
    .i_prompt(s_i_prompt), .q_prompt(s_q_prompt), .i_late(s_i_late), .q_late(s_q_late),
    .dump_valid(s_dump_valid), .accum_ready(s_accum_ready), .overrun(s_overrun),
    .epoch(s_epoch)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (16-bit instance), in plain integers.
  int m_acc[6];
  int m_lat[6];
  bit m_ready, m_ovr, m_dv;
  int m_epoch;

  function automatic int fit(input int v);
`ifdef CODE_ACCUM_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    return int'(shortint'(v));
`endif
  endfunction

  // Index order: i_early, q_early, i_prompt, q_prompt, i_late, q_late.
  function automatic int dut_lat(input int k);
    case (k)
      0: return int'(i_early);
      1: return int'(q_early);
      2: return int'(i_prompt);
      3: return int'(q_prompt);
      4: return int'(i_late);
      default: return int'(q_late);
    endcase
  endfunction

  // Apply the behaviour rules to the inputs currently on the pins.
  function automatic void model_step();
    int  p[6];
    int  is, qs;
    bit  dmp;
    is = int'(i_sample);
    qs = int'(q_sample);
    p[0] = early  ? is : -is;  p[1] = early  ? qs : -qs;
    p[2] = prompt ? is : -is;  p[3] = prompt ? qs : -qs;
    p[4] = late   ? is : -is;  p[5] = late   ? qs : -qs;
    if (rst) begin
      foreach (m_acc[k]) begin m_acc[k] = 0; m_lat[k] = 0; end
      m_ready = 0; m_ovr = 0; m_dv = 0; m_epoch = 0;
      return;
    end
    dmp = ch_enable && dump_enable;
    for (int k = 0; k < 6; k++) begin
      if (dmp) m_lat[k] = fit(m_acc[k] + (sample_valid ? p[k] : 0));
      if (!ch_enable || dmp) m_acc[k] = 0;
      else if (sample_valid) m_acc[k] = fit(m_acc[k] + p[k]);
    end
    if (dmp && m_ready && !status_read) m_ovr = 1;
    else if (status_read) m_ovr = 0;
    if (dmp) m_ready = 1;
    else if (status_read) m_ready = 0;
    m_dv = dmp;
    if (epoch_load) m_epoch = (epoch_load_val >= 5'd20) ? 0 : int'(epoch_load_val);
    else if (dmp) m_epoch = (m_epoch + 1) % 20;
  endfunction

  // One clock: update model, cross the rising edge, park on the falling edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; ch_enable = 1; sample_valid = 0; early = 0; prompt = 0; late = 0;
    dump_enable = 0; status_read = 0; epoch_load = 0; epoch_load_val = '0;
    i_sample = '0; q_sample = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      n_vec++;
      if (dut_lat(k) !== 0) begin
        n_err++; $display("FAIL reset_lat%0d got %0d want 0", k, dut_lat(k));
      end
    end
    n_vec++;
    if ({dump_valid, accum_ready, overrun, epoch} !== 8'd0) begin
      n_err++; $display("FAIL reset_flags got dv=%0b rdy=%0b ovr=%0b ep=%0d want 0",
                        dump_valid, accum_ready, overrun, epoch);
    end
  endtask

  task automatic test_despread();
    int exp_v[6];
    exp_v = '{-300, 100, 300, -100, 300, -100};
    do_reset();
    i_sample = 3'sd3; q_sample = -3'sd1; prompt = 1; early = 0; late = 1;
    sample_valid = 1;
    repeat (100) tick();
    sample_valid = 0; dump_enable = 1;
    tick();
    dump_enable = 0;
    for (int k = 0; k < 6; k++) begin
      n_vec++;
      if (dut_lat(k) !== exp_v[k]) begin
        n_err++; $display("FAIL despread_lat%0d got %0d want %0d", k, dut_lat(k), exp_v[k]);
      end
    end
    n_vec++;
    if (dump_valid !== 1'b1 || accum_ready !== 1'b1) begin
      n_err++; $display("FAIL despread_pulse got dv=%0b rdy=%0b want 1 1", dump_valid, accum_ready);
    end
    tick();
    n_vec++;
    if (dump_valid !== 1'b0 || accum_ready !== 1'b1) begin
      n_err++; $display("FAIL despread_after got dv=%0b rdy=%0b want 0 1", dump_valid, accum_ready);
    end
  endtask

  task automatic test_sat_and_neg();
    int exp8;
`ifdef CODE_ACCUM_SAT_EN
    exp8 = 127;
`else
    exp8 = 44;
`endif
    do_reset();
    i_sample = 3'sd3; prompt = 1; sample_valid = 1;
    repeat (100) tick();
    sample_valid = 0; dump_enable = 1;
    tick();
    dump_enable = 0;
    n_vec++;
    if (int'(s_i_prompt) !== exp8) begin
      n_err++; $display("FAIL acc8_i_prompt got %0d want %0d", s_i_prompt, exp8);
    end
    i_sample = -3'sd4; prompt = 0; sample_valid = 1;
    tick();
    sample_valid = 0; dump_enable = 1;
    tick();
    dump_enable = 0;
    n_vec++;
    if (int'(i_prompt) !== 4 || int'(s_i_prompt) !== 4) begin
      n_err++; $display("FAIL neg_min got %0d/%0d want 4/4", i_prompt, s_i_prompt);
    end
  endtask

  task automatic test_flags();
    do_reset();
    dump_enable = 1;
    tick();
    tick();
    dump_enable = 0;
    n_vec++;
    if (accum_ready !== 1'b1 || overrun !== 1'b1) begin
      n_err++; $display("FAIL two_dumps got rdy=%0b ovr=%0b want 1 1", accum_ready, overrun);
    end
    status_read = 1;
    tick();
    status_read = 0;
    n_vec++;
    if (accum_ready !== 1'b0 || overrun !== 1'b0) begin
      n_err++; $display("FAIL read_clear got rdy=%0b ovr=%0b want 0 0", accum_ready, overrun);
    end
    dump_enable = 1;
    tick();
    n_vec++;
    if (accum_ready !== 1'b1 || overrun !== 1'b0) begin
      n_err++; $display("FAIL dump_single got rdy=%0b ovr=%0b want 1 0", accum_ready, overrun);
    end
    status_read = 1;
    tick();
    n_vec++;
    if (accum_ready !== 1'b1 || overrun !== 1'b0) begin
      n_err++; $display("FAIL dump_and_read got rdy=%0b ovr=%0b want 1 0", accum_ready, overrun);
    end
    status_read = 0;
    tick();
    status_read = 1;
    tick();
    status_read = 0; dump_enable = 0;
    n_vec++;
    if (accum_ready !== 1'b1 || overrun !== 1'b0) begin
      n_err++; $display("FAIL ovr_then_read got rdy=%0b ovr=%0b want 1 0", accum_ready, overrun);
    end
  endtask

  task automatic test_epoch();
    do_reset();
    dump_enable = 1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      n_vec++;
      if (int'(epoch) !== k % 20) begin
        n_err++; $display("FAIL epoch_seq%0d got %0d want %0d", k, epoch, k % 20);
      end
    end
    epoch_load = 1; epoch_load_val = 5'd17;
    tick();
    n_vec++;
    if (epoch !== 5'd17) begin
      n_err++; $display("FAIL epoch_load17 got %0d want 17", epoch);
    end
    epoch_load_val = 5'd25;
    tick();
    epoch_load = 0; dump_enable = 0;
    n_vec++;
    if (epoch !== 5'd0) begin
      n_err++; $display("FAIL epoch_load25 got %0d want 0", epoch);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    prompt = 1; sample_valid = 1;
    for (int n = 0; n < 50; n++) begin
      i_sample = 3'($urandom); q_sample = 3'($urandom);
      dump_enable = (n == 20) || (n == 30);
      tick();
    end
    dump_enable = 0;
    rst = 1;
    tick();
    rst = 0;
    n_vec++;
    if ({dump_valid, accum_ready, overrun, epoch} !== 8'd0 || i_prompt !== 16'sd0) begin
      n_err++; $display("FAIL mid_reset got dv=%0b rdy=%0b ovr=%0b ep=%0d ip=%0d want 0",
                        dump_valid, accum_ready, overrun, epoch, i_prompt);
    end
    i_sample = 3'sd1; q_sample = '0;
    repeat (10) tick();
    sample_valid = 0; dump_enable = 1;
    tick();
    dump_enable = 0;
    n_vec++;
    if (int'(i_prompt) !== 10) begin
      n_err++; $display("FAIL mid_reset_resume got %0d want 10", i_prompt);
    end
  endtask

  task automatic test_disable();
    int saved[6];
    do_reset();
    early = 1; late = 0; prompt = 1; sample_valid = 1;
    i_sample = 3'sd2; q_sample = -3'sd3;
    repeat (7) tick();
    dump_enable = 1;
    tick();
    saved = m_lat;
    ch_enable = 0;
    for (int n = 0; n < 20; n++) begin
      i_sample = 3'($urandom); q_sample = 3'($urandom);
      sample_valid = 1'($urandom); dump_enable = 1'($urandom);
      tick();
      n_vec++;
      if (dump_valid !== 1'b0) begin
        n_err++; $display("FAIL disabled_dv cycle %0d got %0b want 0", n, dump_valid);
      end
    end
    for (int k = 0; k < 6; k++) begin
      n_vec++;
      if (dut_lat(k) !== saved[k]) begin
        n_err++; $display("FAIL disabled_hold%0d got %0d want %0d", k, dut_lat(k), saved[k]);
      end
    end
    ch_enable = 1; sample_valid = 0; dump_enable = 1;
    tick();
    n_vec++;
    if (int'(i_early) !== 0 || int'(q_prompt) !== 0) begin
      n_err++; $display("FAIL reenable_zero got %0d/%0d want 0/0", i_early, q_prompt);
    end
    dump_enable = 0; sample_valid = 1; i_sample = 3'sd2; early = 1;
    repeat (5) tick();
    sample_valid = 0; dump_enable = 1;
    tick();
    dump_enable = 0;
    n_vec++;
    if (int'(i_early) !== 10) begin
      n_err++; $display("FAIL reenable_int got %0d want 10", i_early);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst            = ($urandom % 150) == 0;
      ch_enable      = ($urandom % 12) != 0;
      sample_valid   = ($urandom % 4) != 0;
      i_sample       = 3'($urandom);
      q_sample       = 3'($urandom);
      early          = 1'($urandom);
      prompt         = 1'($urandom);
      late           = 1'($urandom);
      dump_enable    = ($urandom % 7) == 0;
      status_read    = ($urandom % 5) == 0;
      epoch_load     = ($urandom % 40) == 0;
      epoch_load_val = 5'($urandom);
      tick();
      for (int k = 0; k < 6; k++) begin
        n_vec++;
        if (dut_lat(k) !== m_lat[k]) begin
          n_err++; $display("FAIL rand%0d_lat%0d got %0d want %0d", n, k, dut_lat(k), m_lat[k]);
        end
      end
      n_vec++;
      if (dump_valid !== m_dv || accum_ready !== m_ready || overrun !== m_ovr ||
          int'(epoch) !== m_epoch) begin
        n_err++;
        $display("FAIL rand%0d_status got dv=%0b rdy=%0b ovr=%0b ep=%0d want %0b %0b %0b %0d",
                 n, dump_valid, accum_ready, overrun, epoch, m_dv, m_ready, m_ovr, m_epoch);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_despread();
    test_sat_and_neg();
    test_flags();
    test_epoch();
    test_reset_mid();
    test_disable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/code_accum.md
Name: code_accum

Overview:
- Consumer end of the code generator's early/prompt/late/dump_enable interface. One per tracking channel.
- Despreads carrier-wiped baseband I/Q samples against the three local code replicas and integrates them.
- On each dump_enable, latches six integrations for the tracking processor and sets a read-cleared ready flag with overrun detection.
- Maintains a 1 ms epoch counter (0..19) for bit-edge bookkeeping.

Parameters:
- SAMPLE_W, 3: width of signed two's-complement i_sample/q_sample.
- ACC_W, 16: width of accumulators and latched outputs.

Ports:
- clk  in  1  system clock (16.368 MHz)
- rst  in  1  synchronous reset, active-high
- ch_enable  in  1  channel enable; low holds accumulators at zero and ignores dumps
- sample_valid  in  1  sample strobe; accumulate only when high
- i_sample  in  SAMPLE_W  signed in-phase sample
- q_sample  in  SAMPLE_W  signed quadrature sample
- early  in  1  early code chip (1 maps to +1, 0 maps to -1)
- prompt  in  1  prompt code chip
- late  in  1  late code chip
- dump_enable  in  1  one-cycle end-of-code-period pulse
- status_read  in  1  one-cycle pulse; clears accum_ready and overrun
- epoch_load  in  1  load epoch counter
- epoch_load_val  in  5  value to load
- i_early, q_early, i_prompt, q_prompt, i_late, q_late  out  ACC_W each  latched signed integrations
- dump_valid  out  1  one-cycle pulse when new latched values appear
- accum_ready  out  1  sticky: new data available
- overrun  out  1  sticky: dump occurred while accum_ready already set
- epoch  out  5  epoch count, 0..19

Behaviour:
- Reset (rst=1 at clk edge): all accumulators, latched outputs, dump_valid, accum_ready, overrun and epoch go to 0. Reset mid-integration discards the partial sum.
- Product: sign-extend each sample to ACC_W, then negate it when the code bit is 0. The most negative sample is negated without overflow (-4 becomes +4).
- Accumulate: on each cycle with ch_enable=1 and sample_valid=1, each of the six accumulators adds its product.
- Accumulation arithmetic is two's-complement wrap modulo 2^ACC_W unless CODE_ACCUM_SAT_EN is defined.
- Dump (ch_enable=1 and dump_enable=1):
  - The latched outputs receive accumulator plus the same-cycle product when sample_valid=1, otherwise the accumulator alone.
  - Accumulators restart at 0.
  - dump_valid pulses on the following cycle; the latched values are visible in that same cycle.
- accum_ready: set one cycle after a dump; cleared by status_read. A dump and status_read in the same cycle leave it set (set wins).
- overrun:
  - Set when a dump occurs while accum_ready=1.
  - Cleared by status_read.
  - When a dump and status_read arrive in the same cycle with accum_ready=1, overrun is cleared: the read consumed the old data.
  - A fresh overrun still wins over the clear.
- Epoch:
  - Increments on each dump, wrapping 19 to 0.
  - epoch_load has priority over a same-cycle dump and loads epoch_load_val.
  - A load value of 20 or more loads 0.
- ch_enable=0: accumulators are held at 0 and dump_enable is ignored. Latched outputs, flags and epoch keep their values; epoch_load still works.
- Latched outputs change only on dumps or reset.

Optional Feature:
- Macro CODE_ACCUM_SAT_EN.
- Defined: each accumulate and dump-add saturates to +(2^(ACC_W-1)-1) or -2^(ACC_W-1).
- Undefined: plain wrap-around addition.
- Ports are identical in both builds.

Decomposition:
- Package code_accum_pkg holds:
  - localparams EPOCH_MAX=19 and EPOCH_W=5
  - function sat_add(a, b) used under CODE_ACCUM_SAT_EN
  - typedef acc_t, signed [ACC_W-1:0], parameterised through a package parameter default of 16
- Sub-module code_accum_arm (one code replica, I and Q accumulators with dump latch) is instantiated three times, for early, prompt and late.

Test Plan:
- i=+3, q=-1, prompt=1, early=0, late=1, 100 valid samples, then dump -> i_prompt=300, q_prompt=-100, i_early=-300, q_early=100, i_late=300; dump_valid for one cycle; accum_ready=1.
- ACC_W=8, i=+3, prompt=1, 100 samples -> i_prompt=127 with CODE_ACCUM_SAT_EN, 44 without; i=-4 with prompt=0 for one sample -> +4.
- Two dumps with no status_read -> overrun=1. Then status_read alone -> accum_ready=0 and overrun=0. Dump plus status_read in the same cycle with accum_ready=1 -> accum_ready=1, overrun=0.
- 25 dumps from reset -> epoch sequence 1..19, 0..5. epoch_load=1 with value 17 in the same cycle as a dump -> epoch=17. Value 25 -> epoch=0.
- Assert rst after 50 accumulating samples, release, 10 samples of +1 prompt, then dump -> i_prompt=10 and all flags reset to 0 in between.
- ch_enable=0 with dumps and samples -> no dump_valid, outputs unchanged, accumulators 0. Re-enabling starts integration from 0.
